// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the host-side PS/2 keyboard receiver:
//   - prefix byte values (extended / release)
//   - frame length in bits (start + 8 data + parity + stop)
//   - frame FSM state encoding
//   - key event record layout (bit 9 ext, bit 8 release, [7:0] scancode)
package ps2_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_EVT_W      = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } ps2_event_t;

    // Odd parity: the eight data bits plus the parity bit carry an odd number of ones.
    function automatic logic ps2_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo
// Show-ahead event queue of 2^FIFO_BITS entries. The head entry is visible on
// o_data whenever o_empty is low. A push and a pop in the same cycle are both
// performed, even when the queue is full. A push into a full queue without a
// pop is dropped silently; the caller detects that case from o_full.
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_push, i_data      write request and entry
//   i_pop               remove head (ignored when empty)
//   o_data              head entry (0 when empty)
//   o_empty, o_full     occupancy flags
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_BITS = 3,
    parameter int WIDTH     = PS2_EVT_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int DEPTH = 1 << FIFO_BITS;

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [FIFO_BITS-1:0] r_wptr;
    logic [FIFO_BITS-1:0] r_rptr;
    logic [FIFO_BITS:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == DEPTH[FIFO_BITS:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = o_empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_host_rx.sv
// ps2_host_rx
// Host-side PS/2 keyboard receiver. Synchronizes and glitch-filters the PS/2
// pins, deframes 11-bit frames on filtered clock falling edges, checks start,
// odd parity and stop, folds 0xE0/0xF0 prefixes into the following byte and
// queues {ext, release, code} events. An inter-bit watchdog aborts stalled frames.
// Ports:
//   i_clk, i_reset                 core clock, synchronous active-high reset
//   i_ps2_clk, i_ps2_data          raw PS/2 pins (asynchronous)
//   o_key_valid                    event queue non-empty
//   o_key_code/ext/release         head event
//   i_key_ack                      pop head event
//   o_rx_err                       one-cycle pulse on frame error or timeout
//   o_overflow                     sticky: an event was dropped on a full queue
//
// state     | meaning
// ST_IDLE   | waiting for a start bit (data=0 on strobe)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the parity bit
// ST_STOP   | checking the stop bit and judging the frame
module ps2_host_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 20000,
    parameter int FIFO_BITS  = 3
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_key_valid,
    output logic [7:0] o_key_code,
    output logic       o_key_ext,
    output logic       o_key_release,
    input  logic       i_key_ack,
    output logic       o_rx_err,
    output logic       o_overflow
);

    logic r_clk_s1, r_clk_s2;
    logic r_dat_s1, r_dat_s2;

    logic       r_filt_clk;
    logic [7:0] r_filt_cnt;
    logic       w_strobe;

    ps2_state_t  r_state, w_next;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_parity;
    logic        r_ext_pend;
    logic        r_rel_pend;
    logic [15:0] r_wd;
    logic        r_rx_err;
    logic        r_overflow;

    logic w_start_err;
    logic w_frame_done;
    logic w_frame_good;
    logic w_frame_bad;
    logic w_timeout;
    logic w_is_ext;
    logic w_is_rel;
    logic w_push;
    logic w_pop;
    logic w_drop;

    ps2_event_t w_evt_in;
    ps2_event_t w_evt_out;
    logic       w_empty;
    logic       w_full;

    // Idle PS/2 lines are high, so the synchronizers come out of reset high
    // to avoid a false falling edge on the first cycles after reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= i_ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= i_ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // r_filt_cnt counts consecutive cycles the synchronized clock disagrees
    // with the filtered level; any agreeing cycle restarts the count.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_filt_clk <= 1'b1;
            r_filt_cnt <= '0;
        end else if (r_clk_s2 == r_filt_clk) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt == 8'(FILTER_LEN - 1)) begin
            r_filt_clk <= r_clk_s2;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

    assign w_strobe  = r_filt_clk && !r_clk_s2 && (r_filt_cnt == 8'(FILTER_LEN - 1));
    assign w_timeout = (r_state != ST_IDLE) && (r_wd == 16'(TIMEOUT));

    always_comb begin
        w_next       = r_state;
        w_start_err  = 1'b0;
        w_frame_done = 1'b0;
        if (w_timeout) begin
            w_next = ST_IDLE;
        end else if (w_strobe) begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_dat_s2) w_next = ST_DATA;
                    else           w_start_err = 1'b1;
                end
                ST_DATA: begin
                    if (r_bit_cnt == 4'd8) w_next = ST_PARITY;
                end
                ST_PARITY: w_next = ST_STOP;
                ST_STOP: begin
                    w_next       = ST_IDLE;
                    w_frame_done = 1'b1;
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    assign w_frame_good = w_frame_done && r_dat_s2
                          && (r_bit_cnt == 4'(PS2_FRAME_BITS - 1))
                          && ps2_parity_ok(r_shift, r_parity);
    assign w_frame_bad  = w_frame_done && !w_frame_good;
    assign w_is_ext     = (r_shift == PS2_PREFIX_EXT);
    assign w_is_rel     = (r_shift == PS2_PREFIX_REL);
    assign w_push       = w_frame_good && !w_is_ext && !w_is_rel;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_ext_pend <= 1'b0;
            r_rel_pend <= 1'b0;
            r_wd       <= '0;
            r_rx_err   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_next == ST_IDLE) begin
                r_bit_cnt <= '0;
            end else if (w_strobe) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            if (w_strobe && (r_state == ST_DATA)) begin
                r_shift <= {r_dat_s2, r_shift[7:1]};
            end
            if (w_strobe && (r_state == ST_PARITY)) begin
                r_parity <= r_dat_s2;
            end

            if (w_timeout || w_frame_bad) begin
                r_ext_pend <= 1'b0;
                r_rel_pend <= 1'b0;
            end else if (w_frame_good) begin
                if (w_is_ext) begin
                    r_ext_pend <= 1'b1;
                end else if (w_is_rel) begin
                    r_rel_pend <= 1'b1;
                end else begin
                    r_ext_pend <= 1'b0;
                    r_rel_pend <= 1'b0;
                end
            end

            if ((r_state == ST_IDLE) || w_strobe) begin
                r_wd <= '0;
            end else if (r_wd != 16'(TIMEOUT)) begin
                r_wd <= r_wd + 1'b1;
            end

            r_rx_err   <= w_start_err || w_frame_bad || w_timeout;
            r_overflow <= r_overflow || w_drop;
        end
    end

    assign w_evt_in = '{ext: r_ext_pend, rel: r_rel_pend, code: r_shift};
    assign w_pop    = i_key_ack && !w_empty;
    assign w_drop   = w_push && w_full && !w_pop;

    ps2_event_fifo #(
        .FIFO_BITS (FIFO_BITS),
        .WIDTH     (PS2_EVT_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_data  (w_evt_in),
        .i_pop   (w_pop),
        .o_data  (w_evt_out),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign o_key_valid   = !w_empty;
    assign o_key_code    = w_evt_out.code;
    assign o_key_ext     = w_evt_out.ext;
    assign o_key_release = w_evt_out.rel;
    assign o_rx_err      = r_rx_err;
    assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_ps2_host_rx.sv
// tb_ps2_host_rx
// Directed bench for ps2_host_rx: a PS/2 device model drives frames, expected
// events go into a scoreboard queue when a frame is sent and are popped and
// compared when the receiver presents them. rx_err high cycles are counted by
// a monitor so pulse counts/widths can be compared per scenario.
module tb_ps2_host_rx;

    localparam int FL      = 8;
    localparam int TMO     = 1000;
    localparam int HALF    = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;
    logic       key_ack;
    logic       rx_err;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    int err_cycles = 0;
    int err0;

    logic [9:0] sb[$];

    ps2_host_rx #(
        .FILTER_LEN (FL),
        .TIMEOUT    (TMO),
        .FIFO_BITS  (3)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_ps2_clk     (ps2_clk),
        .i_ps2_data    (ps2_data),
        .o_key_valid   (key_valid),
        .o_key_code    (key_code),
        .o_key_ext     (key_ext),
        .o_key_release (key_release),
        .i_key_ack     (key_ack),
        .o_rx_err      (rx_err),
        .o_overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_err === 1'b1) err_cycles++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives bits [0..nbits-1] of a frame; a glitch_bit >= 0 inserts a short
    // low pulse on ps2_clk during the high phase of that bit.
    task automatic send_frame(input logic [7:0] b, input logic bad_par,
                              input int nbits, input int glitch_bit);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            if (i == glitch_bit) begin
                cyc(4);
                ps2_clk = 1'b0;
                cyc(FL - 2);
                ps2_clk = 1'b1;
                cyc(HALF - 4 - (FL - 2));
            end else begin
                cyc(HALF);
            end
            ps2_clk = 1'b0;
            cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        cyc(HALF);
    endtask

    task automatic check_head(input string tag);
        int n;
        logic [9:0] exp;
        n = 0;
        @(negedge clk);
        while (key_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(key_valid), 32'd1);
        check({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
        exp = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
        check(tag, 32'({key_ext, key_release, key_code}), 32'(exp));
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_valid"}, 32'(key_valid), 32'd0);
        check({tag, "_code"}, 32'(key_code), 32'd0);
        check({tag, "_ext"}, 32'(key_ext), 32'd0);
        check({tag, "_rel"}, 32'(key_release), 32'd0);
        check({tag, "_err"}, 32'(rx_err), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        key_ack  = 1'b0;
        cyc(5);
        check_reset_outputs("rst");
        reset = 1'b0;
        cyc(5);

        // Single make code
        sb.push_back({2'b00, 8'h1C});
        send_frame(8'h1C, 1'b0, 11, -1);
        check_head("t1_1c");
        check("t1_empty", 32'(key_valid), 32'd0);

        // Extended release: E0 F0 75
        err0 = err_cycles;
        sb.push_back({2'b11, 8'h75});
        send_frame(8'hE0, 1'b0, 11, -1);
        send_frame(8'hF0, 1'b0, 11, -1);
        send_frame(8'h75, 1'b0, 11, -1);
        check_head("t2_e0f075");
        check("t2_single", 32'(key_valid), 32'd0);
        check("t2_noerr", 32'(err_cycles - err0), 32'd0);

        // Extended make only
        sb.push_back({2'b10, 8'h6B});
        send_frame(8'hE0, 1'b0, 11, -1);
        send_frame(8'h6B, 1'b0, 11, -1);
        check_head("t2b_e06b");

        // Parity error, then recovery
        err0 = err_cycles;
        send_frame(8'h1C, 1'b1, 11, -1);
        cyc(20);
        check("t3_errpulse", 32'(err_cycles - err0), 32'd1);
        check("t3_noevent", 32'(key_valid), 32'd0);
        sb.push_back({2'b00, 8'h1C});
        send_frame(8'h1C, 1'b0, 11, -1);
        check_head("t3_recover");

        // A bad frame discards a pending release prefix
        err0 = err_cycles;
        send_frame(8'hF0, 1'b0, 11, -1);
        send_frame(8'h1C, 1'b1, 11, -1);
        sb.push_back({2'b00, 8'h1C});
        send_frame(8'h1C, 1'b0, 11, -1);
        check_head("t3b_clrpend");
        check("t3b_err", 32'(err_cycles - err0), 32'd1);

        // Watchdog abort after four bits
        err0 = err_cycles;
        send_frame(8'h55, 1'b0, 4, -1);
        cyc(TMO + 10);
        check("t4_timeout", 32'(err_cycles - err0), 32'd1);
        check("t4_noevent", 32'(key_valid), 32'd0);
        sb.push_back({2'b00, 8'h29});
        send_frame(8'h29, 1'b0, 11, -1);
        check_head("t4_29");

        // Overflow: nine frames, eight slots
        for (int k = 1; k <= 9; k++) begin
            if (k <= 8) sb.push_back({2'b00, 8'(k)});
            send_frame(8'(k), 1'b0, 11, -1);
            if (k == 8) check("t5_ovf_before", 32'(overflow), 32'd0);
        end
        check("t5_ovf_set", 32'(overflow), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            check_head("t5_pop");
        end
        check("t5_drained", 32'(key_valid), 32'd0);
        check("t5_ovf_sticky", 32'(overflow), 32'd1);

        // Short low glitch on ps2_clk mid-frame
        err0 = err_cycles;
        sb.push_back({2'b00, 8'h5A});
        send_frame(8'h5A, 1'b0, 11, 4);
        check_head("t6_glitch");
        check("t6_noerr", 32'(err_cycles - err0), 32'd0);

        // Reset mid-frame with an event queued and overflow set
        send_frame(8'h33, 1'b0, 11, -1);
        check("t7_pre_valid", 32'(key_valid), 32'd1);
        send_frame(8'h44, 1'b0, 5, -1);
        reset = 1'b1;
        cyc(2);
        check_reset_outputs("t7_rst");
        reset = 1'b0;
        cyc(5);
        sb.push_back({2'b00, 8'h3C});
        send_frame(8'h3C, 1'b0, 11, -1);
        check_head("t7_after");
        check("t7_empty", 32'(key_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
